pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic pipeline-stage register for the five-stage CPU. It replaces the fixed, always-advancing inter-stage registers with a valid/ready stage. The stage carries an opaque payload of configurable width and supports back-pressure (stall), synchronous flush (bubble insertion) and an optional skid buffer that breaks the combinational ready path. Its first instance is at MEM→WB; the payload packs m2reg, wreg, rn, mo and alu_result.

## Interface
- DW, default 71: payload width in bits; the MEM/WB instance uses 1+1+5+32+32.
- RST_VAL, default 0: payload value loaded on reset, DW bits.
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries and of the current input
- in_valid  in  1  upstream presents a payload
- in_ready  out  1  stage accepts a payload this cycle
- in_data  in  DW  upstream payload
- out_valid  out  1  stage holds a valid payload
- out_ready  in  1  downstream consumes this cycle
- out_data  out  DW  payload presented downstream

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Main register (mreg): holds valid bit mv and payload md. out_valid = mv and out_data = md, driven straight from flops.
- Without skid: in_ready = !mv | out_ready. On a transfer in, mreg loads in_data and mv=1. On a transfer out with no transfer in, mv=0 and md is retained.
- Hold (stall): while mv=1 and out_ready=0, md does not change. out_data is bit-stable across the stall.
- Flush: at the clock edge, all valid bits are cleared and no input is captured that cycle, even if in_valid & in_ready. Payload flops keep their values. in_ready keeps its normal equation during the flush cycle.
- Upstream must hold in_data stable while in_valid=1 and in_ready=0. The stage does not check this.
- No payload is duplicated or reordered. Every accepted, unflushed payload appears at out_data exactly once.

## Timing
- Reset (clrn=0, asynchronous): mv=0, md=RST_VAL, out_valid=0, out_data=RST_VAL. Skid state is cleared. in_ready=1 from the first edge after clrn rises.
- Latency: 1 cycle. Data accepted at edge N is on out_data after edge N.
- Throughput: 1 payload/cycle when out_ready is held at 1.
- Without skid: out_ready→in_ready is a combinational path.
- Simultaneous transfer in and transfer out: mreg is replaced by the new payload and mv stays 1.
- Reset mid-stall: contents are lost and the outputs take their reset values immediately.

## Configuration
- PIPE_SKID_EN defined: a second entry (skid: sv, sd) is added and in_ready = !sv, driven from a flop.
  - A transfer in while mv=1 and out_ready=0 goes into the skid entry.
  - On the next transfer out, skid moves into mreg and sv=0.
  - Order is mreg first, then skid.
  - Full: mv=1 and sv=1 gives in_ready=0.
  - Flush clears both mv and sv.
  - Latency is still 1 cycle when skid is empty.
- PIPE_SKID_EN undefined: single entry and combinational in_ready, as described above. Port list is identical in both builds.

## Structure
- pipe_pkg holds:
  - MEM/WB field widths: CTRL_W=2, RN_W=5, WORD_W=32.
  - Field bit offsets inside the packed payload: m2reg in the MSB, then wreg, rn, mo, and alu_result in the LSBs.
  - The derived DW constant.
- One sub-module, pipe_skid_buf, holds the skid entry and its control. It is instantiated only under PIPE_SKID_EN.

## Test plan
- Reset: clrn=0 with in_valid=1 and in_data=0x7FF…F → out_valid=0 and out_data=0. First edge after release: in_ready=1.
- Streaming: 8 payloads 0x1…0x8 with out_ready=1 → each appears one cycle after acceptance, in order, with no gaps.
- Stall: payload 0xA5 accepted, then out_ready=0 for 4 cycles → out_data stays 0xA5 and out_valid stays 1. Without skid in_ready=0; with skid, one more payload 0x5A is accepted, then in_ready=0. Release → 0xA5 then 0x5A.
- Flush: stage full and flush=1 together with in_valid=1 and in_data=0x33 → out_valid=0 next cycle and 0x33 never appears.
- Simultaneous transfer in and out: out_ready=1 and in_valid=1 every cycle while holding 0x10 → 0x11 on the next cycle, out_valid stays 1.
- Reset mid-stall with skid full → all valid bits 0 immediately, and in_ready=1 after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline-stage register.
// Describes the MEM/WB payload layout: m2reg in the MSB, then wreg, rn, mo,
// with alu_result in the LSBs.
package pipe_pkg;

    localparam int CTRL_W    = 2;
    localparam int RN_W      = 5;
    localparam int WORD_W    = 32;

    localparam int ALU_LSB   = 0;
    localparam int MO_LSB    = ALU_LSB + WORD_W;
    localparam int RN_LSB    = MO_LSB + WORD_W;
    localparam int WREG_BIT  = RN_LSB + RN_W;
    localparam int M2REG_BIT = WREG_BIT + 1;

    localparam int PIPE_DW   = CTRL_W + RN_W + 2 * WORD_W;

    typedef struct packed {
        logic              m2reg;
        logic              wreg;
        logic [RN_W-1:0]   rn;
        logic [WORD_W-1:0] mo;
        logic [WORD_W-1:0] alu_result;
    } memwb_t;

    // Packs the MEM/WB fields into the opaque stage payload.
    function automatic logic [PIPE_DW-1:0] pack_memwb(
        input logic              m2reg,
        input logic              wreg,
        input logic [RN_W-1:0]   rn,
        input logic [WORD_W-1:0] mo,
        input logic [WORD_W-1:0] alu_result
    );
        memwb_t f;
        f.m2reg      = m2reg;
        f.wreg       = wreg;
        f.rn         = rn;
        f.mo         = mo;
        f.alu_result = alu_result;
        return f;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry for pipe_stage_reg. Catches the one payload accepted while the
// main register is stalled, so that upstream ready comes from a flop instead
// of the downstream ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int               DW      = PIPE_DW,
    parameter logic [DW-1:0]    RST_VAL = '0
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          i_flush,
    input  logic          i_load,
    input  logic          i_drain,
    input  logic [DW-1:0] i_data,
    output logic          o_sv,
    output logic [DW-1:0] o_sd,
    output logic          o_ready
);

    logic          r_sv;
    logic [DW-1:0] r_sd;

    // Skid valid/payload: flush wins, then capture on stall, clear on drain.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_sv <= 1'b0;
            r_sd <= RST_VAL;
        end else if (i_flush) begin
            r_sv <= 1'b0;
        end else if (i_load) begin
            r_sv <= 1'b1;
            r_sd <= i_data;
        end else if (i_drain) begin
            r_sv <= 1'b0;
        end
    end

    assign o_sv    = r_sv;
    assign o_sd    = r_sd;
    assign o_ready = ~r_sv;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with stall and synchronous flush.
// Build option PIPE_SKID_EN adds a skid entry (pipe_skid_buf) so in_ready is
// driven from a flop; without it in_ready is combinational from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               DW      = PIPE_DW,
    parameter logic [DW-1:0]    RST_VAL = '0
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          r_mv;
    logic [DW-1:0] r_md;

    logic          w_xfer_in;
    logic          w_xfer_out;
    logic          w_m_load;
    logic [DW-1:0] w_m_data;

    assign w_xfer_out = r_mv & out_ready;
    // A flushed cycle never captures, even when the handshake completes.
    assign w_xfer_in  = in_valid & in_ready & ~flush;

`ifdef PIPE_SKID_EN
    logic          w_sv;
    logic [DW-1:0] w_sd;
    logic          w_skid_ready;
    logic          w_skid_load;
    logic          w_skid_drain;

    // Accepting while the main register is stalled parks the payload in skid.
    assign w_skid_load  = w_xfer_in & r_mv & ~out_ready;
    assign w_skid_drain = w_xfer_out & w_sv;

    pipe_skid_buf #(
        .DW      (DW),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk     (clk),
        .clrn    (clrn),
        .i_flush (flush),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_data  (in_data),
        .o_sv    (w_sv),
        .o_sd    (w_sd),
        .o_ready (w_skid_ready)
    );

    assign in_ready = w_skid_ready;
    // Skid is older than anything upstream, so it refills mreg first.
    // While skid is full in_ready is low, so the two sources never collide.
    assign w_m_load = w_skid_drain | (w_xfer_in & ~w_skid_load);
    assign w_m_data = w_sv ? w_sd : in_data;
`else
    assign in_ready = ~r_mv | out_ready;
    assign w_m_load = w_xfer_in;
    assign w_m_data = in_data;
`endif

    // Main register: flush clears valid only, load replaces, drain empties.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_mv <= 1'b0;
            r_md <= RST_VAL;
        end else if (flush) begin
            r_mv <= 1'b0;
        end else if (w_m_load) begin
            r_mv <= 1'b1;
            r_md <= w_m_data;
        end else if (w_xfer_out) begin
            r_mv <= 1'b0;
        end
    end

    assign out_valid = r_mv;
    assign out_data  = r_md;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; adapts stall expectations when built
// with PIPE_SKID_EN.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = PIPE_DW;

    logic          clk = 1'b0;
    logic          clrn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    pipe_stage_reg #(.DW(DW), .RST_VAL('0)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [DW-1:0] wide;

    initial begin
        clrn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = '1;

        // Reset with input asserted
        repeat (3) @(negedge clk);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        clrn = 1'b1; in_valid = 1'b0; in_data = '0;
        cyc();
        chk("rst_in_ready", DW'(in_ready), 1);
        chk("rst_idle_valid", DW'(out_valid), '0);

        // Streaming 1..8 with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            chk($sformatf("stream_rdy%0d", i), DW'(in_ready), 1);
            cyc();
            chk($sformatf("stream_v%0d", i), DW'(out_valid), 1);
            chk($sformatf("stream_d%0d", i), out_data, DW'(i));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drained", DW'(out_valid), '0);

        // Stall with 0xA5 held, 0x5A offered behind it
        in_valid = 1'b1; in_data = DW'(8'hA5); out_ready = 1'b0;
        cyc();
        in_data = DW'(8'h5A);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_v%0d", k), DW'(out_valid), 1);
            chk($sformatf("stall_d%0d", k), out_data, DW'(8'hA5));
            chk($sformatf("stall_rdy%0d", k), DW'(in_ready), DW'(SKID && k == 0));
            cyc();
        end
        out_ready = 1'b1;
        if (SKID) in_valid = 1'b0;
        chk("stall_rel_d", out_data, DW'(8'hA5));
        cyc();
        in_valid = 1'b0;
        chk("stall_2nd_v", DW'(out_valid), 1);
        chk("stall_2nd_d", out_data, DW'(8'h5A));
        cyc();
        chk("stall_empty", DW'(out_valid), '0);

        // Flush a full stage while 0x33 is offered
        in_valid = 1'b1; in_data = DW'(8'h44); out_ready = 1'b0;
        cyc();
        in_data = DW'(8'h33); flush = 1'b1;
        chk("flush_rdy", DW'(in_ready), DW'(SKID));
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_v", DW'(out_valid), '0);
        chk("flush_d_kept", out_data, DW'(8'h44));
        cyc();
        chk("flush_v2", DW'(out_valid), '0);
        chk("flush_d2", out_data, DW'(8'h44));

        // Simultaneous in and out
        in_valid = 1'b1; in_data = DW'(8'h10);
        cyc();
        chk("sim_d10", out_data, DW'(8'h10));
        in_data = DW'(8'h11);
        chk("sim_rdy", DW'(in_ready), 1);
        cyc();
        chk("sim_v", DW'(out_valid), 1);
        chk("sim_d11", out_data, DW'(8'h11));
        wide = pack_memwb(1'b1, 1'b0, 5'h1F, 32'hDEADBEEF, 32'h12345678);
        in_data = wide;
        cyc();
        chk("sim_wide", out_data, {1'b1, 1'b0, 5'h1F, 32'hDEADBEEF, 32'h12345678});
        in_valid = 1'b0;
        cyc();

        // Reset in the middle of a stall (skid full when enabled)
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h77);
        cyc();
        in_data = DW'(8'h78);
        cyc();
        in_valid = 1'b0;
        chk("mid_rdy_full", DW'(in_ready), '0);
        #2 clrn = 1'b0;
        #1;
        chk("mid_rst_v", DW'(out_valid), '0);
        chk("mid_rst_d", out_data, '0);
        @(negedge clk);
        clrn = 1'b1;
        cyc();
        chk("mid_rel_rdy", DW'(in_ready), 1);
        chk("mid_rel_v", DW'(out_valid), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
